seq_arith_unit: RTL



---
 rtl/seq_arith_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seq_arith_unit.sv
// seq_arith_unit: multi-cycle unsigned add/sub/mul/div with valid/ready
// handshakes on both sides. Only one operation is in flight at a time.
// Add, sub and divide-by-zero finish in the accept cycle. Multiply and
// divide then spend WIDTH BUSY cycles, one bit per cycle.
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               err
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [1:0]         op_r;
    logic [CW-1:0]      cnt;
    // mul: running product. div: {remainder, dividend/quotient shift reg}.
    logic [2*WIDTH-1:0] acc;

    logic [2*WIDTH-1:0] add_res, sub_res;
    logic [2*WIDTH-1:0] mul_next, div_next, step;
    logic [WIDTH:0]     rem_sh, rem_sub;
    logic               ge;
    logic               last;

    assign in_ready = (state_q == IDLE);
    assign last     = (cnt == CW'(WIDTH - 1));

    // Single-cycle results and one mul/div iteration step.
    always_comb begin
        add_res  = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
        sub_res  = {{WIDTH{1'b0}}, a} - {{WIDTH{1'b0}}, b};
        // Shift-add: multiplier bit cnt (LSB first) gates a << cnt.
        mul_next = acc + (b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0);
        // Restoring divide: bring the next dividend MSB into the remainder,
        // subtract if it fits, and shift the quotient bit in at the bottom.
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, b_r};
        ge       = (rem_sh >= {1'b0, b_r});
        div_next = {(ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                    acc[WIDTH-2:0], ge};
        step     = (op_r == OP_MUL) ? mul_next : div_next;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) begin
                if (op == OP_MUL || (op == OP_DIV && b != '0)) state_d = BUSY;
                else                                          state_d = DONE;
            end
            BUSY: if (last)      state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= OP_ADD;
            cnt       <= '0;
            acc       <= '0;
            result    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt <= '0;
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        op_r <= op;
                        case (op)
                            OP_ADD: begin
                                result    <= add_res;
                                err       <= 1'b0;
                                out_valid <= 1'b1;
                            end
                            OP_SUB: begin
                                result    <= sub_res;
                                err       <= 1'b0;
                                out_valid <= 1'b1;
                            end
                            OP_MUL: acc <= '0;
                            default: begin
                                if (b == '0) begin
                                    // Quotient saturates, remainder keeps a.
                                    result    <= {a, {WIDTH{1'b1}}};
                                    err       <= 1'b1;
                                    out_valid <= 1'b1;
                                end else begin
                                    acc <= {{WIDTH{1'b0}}, a};
                                end
                            end
                        endcase
                    end
                end
                BUSY: begin
                    acc <= step;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        result    <= step;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: out_valid <= 1'b0;
            endcase
        end
    end
endmodule
